// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types used by the instruction-memory responder.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INSN_W    = 32;
    localparam int unsigned LAT_CNT_W = 4;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic              err;
        logic [INSN_W-1:0] ins;
    } imem_rsp_t;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
module imem_array
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [INSN_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [INSN_W-1:0] rdata_o_c
);

    logic [INSN_W-1:0] mem_q [DEPTH];

    // Contents are never cleared; the reset edge only blocks writes while held low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni && we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o_c = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed latency and address checking.
module imem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned        LATENCY = 2,
    parameter int unsigned        DEPTH   = 1024,
    parameter logic [XLEN-1:0]    BASE    = PC_RESET,
    localparam int unsigned       AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [XLEN-1:0]   req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [INSN_W-1:0] rsp_ins_o,
    output logic              rsp_err_o,
    input  logic              load_en_i,
    input  logic [AW-1:0]     load_addr_i,
    input  logic [INSN_W-1:0] load_data_i
);

    localparam int unsigned      CNT_W = LAT_CNT_W;
    localparam int unsigned      AXW   = XLEN + 1;
    localparam logic [AXW-1:0]   SPAN  = AXW'(DEPTH) << 2;

    imem_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               req_ready_q, req_ready_d;
    imem_rsp_t          rsp_q, rsp_d;

    logic               enter_resp_c;
    logic [XLEN-1:0]    look_addr_c;
    logic [AXW-1:0]     off_c;
    logic               err_c;
    logic [AW-1:0]      index_c;
    logic [INSN_W-1:0]  rdata_c;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (load_en_i),
        .waddr_i   (load_addr_i),
        .wdata_i   (load_data_i),
        .raddr_i   (index_c),
        .rdata_o_c (rdata_c)
    );

    // With LATENCY=1 the lookup happens on the acceptance edge, so use the live address.
    always_comb begin
        look_addr_c = (state_q == IDLE) ? req_addr_i : addr_q;
        off_c       = {1'b0, look_addr_c} - {1'b0, BASE};
        err_c       = (look_addr_c[1:0] != 2'b00) || (look_addr_c < BASE) || (off_c >= SPAN);
        index_c     = off_c[AW+1:2];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_d        = rsp_q;
        enter_resp_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    addr_d = req_addr_i;
                    if (LATENCY <= 1) begin
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Word is captured on the RESP entry edge; a same-edge load lands afterwards.
        if (enter_resp_c) begin
            state_d     = RESP;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_d.err   = err_c;
            rsp_d.ins   = err_c ? '0 : rdata_c;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_ins_o   = rsp_q.ins;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 2, 1, 4) against an array-based fetch model.
module tb_imem_responder;

    localparam int unsigned NDUT  = 3;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_ins   [NDUT];
    logic        rsp_err   [NDUT];
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_responder #(
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_ins_o   (rsp_ins[g]),
            .rsp_err_o   (rsp_err[g]),
            .load_en_i   (load_en),
            .load_addr_i (load_addr),
            .load_data_i (load_data)
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    // Expected {err, ins} for a fetch, straight from the address rules.
    function automatic logic [32:0] ref_fetch(input logic [31:0] a);
        longint unsigned av, lo, hi;
        av = longint'(a);
        lo = longint'(BASE);
        hi = lo + 4 * longint'(DEPTH);
        if ((av % 4) != 0 || av < lo || av >= hi) return {1'b1, 32'h0};
        return {1'b0, model_mem[int'((av - lo) / 4)]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL timeout %s: observed no event expected event within bound", tag);
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 10'(idx);
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
        model_mem[idx] = data;
    endtask

    // Issue one fetch on instance d; hold = cycles of rsp_ready=0 once the response shows.
    task automatic fetch(input int d, input logic [31:0] a, input int hold);
        logic [32:0] e;
        int          t;
        int          k;
        e = ref_fetch(a);
        t = 0;
        while (!req_ready[d] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[d]) begin
            timeout($sformatf("d%0d req_ready", d));
            return;
        end
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        rsp_ready[d] = (hold == 0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        k = 1;
        while (!rsp_valid[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid[d]) begin
            timeout($sformatf("d%0d rsp_valid", d));
            rsp_ready[d] = 1'b0;
            return;
        end
        check($sformatf("d%0d latency a=%h", d, a), 64'(k), 64'(lat_of(d)));
        check($sformatf("d%0d rsp_ins a=%h", d, a), 64'(rsp_ins[d]), 64'(e[31:0]));
        check($sformatf("d%0d rsp_err a=%h", d, a), 64'(rsp_err[d]), 64'(e[32]));
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'($urandom_range(0, 1));
            req_addr[d]  = $urandom;
            @(negedge clk);
            check($sformatf("d%0d hold%0d valid", d, i), 64'(rsp_valid[d]), 64'(1));
            check($sformatf("d%0d hold%0d ins", d, i), 64'(rsp_ins[d]), 64'(e[31:0]));
            check($sformatf("d%0d hold%0d err", d, i), 64'(rsp_err[d]), 64'(e[32]));
            check($sformatf("d%0d hold%0d ready", d, i), 64'(req_ready[d]), 64'(0));
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        check($sformatf("d%0d rsp_valid after hs", d), 64'(rsp_valid[d]), 64'(0));
        check($sformatf("d%0d req_ready after hs", d), 64'(req_ready[d]), 64'(1));
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] old_word;
        logic [31:0] a;
        int          d;
        int          kind;

        rst_n   = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < NDUT; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b0;
        end

        #2;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("d%0d reset rsp_valid", i), 64'(rsp_valid[i]), 64'(0));
            check($sformatf("d%0d reset rsp_ins", i), 64'(rsp_ins[i]), 64'(0));
            check($sformatf("d%0d reset rsp_err", i), 64'(rsp_err[i]), 64'(0));
            check($sformatf("d%0d reset req_ready", i), 64'(req_ready[i]), 64'(0));
        end
        @(negedge clk);
        @(negedge clk);
        check("d0 req_ready held in reset", 64'(req_ready[0]), 64'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("d%0d req_ready after release", i), 64'(req_ready[i]), 64'(1));

        for (int i = 0; i < DEPTH; i++)
            load_word(i, (i == 0) ? 32'h3C01_1234 : $urandom);

        fetch(0, 32'h0000_3000, 0);
        check("word0 program value", 64'(rsp_ins[0]), 64'(32'h3C01_1234));
        fetch(0, 32'h0000_3002, 0);
        fetch(0, 32'h0000_2FFC, 0);
        fetch(0, 32'h0000_4000, 0);
        fetch(0, 32'h0000_3FFC, 1);
        fetch(0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 5);

        fetch(1, 32'h0000_3000, 0);
        fetch(1, 32'h0000_3004, 0);
        fetch(2, 32'h0000_3000, 0);
        fetch(2, 32'h0000_3004, 0);

        // Load index 1 on the same edge that enters RESP for 0x3004 on the LATENCY=4 instance.
        old_word = model_mem[1];
        check("rbw req_ready", 64'(req_ready[2]), 64'(1));
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h0000_3004;
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rbw not early", 64'(rsp_valid[2]), 64'(0));
        load_en   = 1'b1;
        load_addr = 10'd1;
        load_data = 32'hFFFF_FFFF;
        @(negedge clk);
        load_en = 1'b0;
        model_mem[1] = 32'hFFFF_FFFF;
        check("rbw rsp_valid", 64'(rsp_valid[2]), 64'(1));
        check("rbw old word", 64'(rsp_ins[2]), 64'(old_word));
        check("rbw rsp_err", 64'(rsp_err[2]), 64'(0));
        @(negedge clk);
        check("rbw pulse", 64'(rsp_valid[2]), 64'(0));
        rsp_ready[2] = 1'b0;
        fetch(2, 32'h0000_3004, 0);
        check("rbw new word", 64'(rsp_ins[2]), 64'(32'hFFFF_FFFF));

        // Asynchronous reset in the middle of WAIT, plus a load attempt while held.
        old_word = model_mem[5];
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h0000_3008;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("mid-wait req_ready", 64'(req_ready[2]), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        check("async rst rsp_valid", 64'(rsp_valid[2]), 64'(0));
        check("async rst req_ready", 64'(req_ready[2]), 64'(0));
        check("async rst rsp_ins", 64'(rsp_ins[2]), 64'(0));
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = ~old_word;
        @(negedge clk);
        load_en = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post-rst req_ready", 64'(req_ready[2]), 64'(1));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("post-rst no rsp %0d", i), 64'(rsp_valid[2]), 64'(0));
            @(negedge clk);
        end
        fetch(2, 32'h0000_3014, 0);
        check("load ignored in reset", 64'(rsp_ins[2]), 64'(old_word));

        for (int n = 0; n < 40; n++) begin
            d    = int'($urandom_range(0, NDUT - 1));
            kind = int'($urandom_range(0, 6));
            a    = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            case (kind)
                3: a = a + 32'($urandom_range(1, 3));
                4: a = 32'($urandom_range(0, 32'h2FFF));
                5: a = 32'h0000_4000 + 32'($urandom_range(0, 32'h000F_FFFF));
                6: a = 32'hFFFF_FFFC;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            fetch(d, a, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter: LATENCY, 2, cycles from request acceptance edge to rsp_valid rising edge, legal range 1..15.
REQ-002 Parameter: DEPTH, 1024, instruction words stored.
REQ-003 Parameter: BASE, 32'h00003000, byte address of word 0.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  fetch request present.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_addr  in  32  fetch byte address (PC value).
REQ-009 rsp_valid  out  1  response word present.
REQ-010 rsp_ready  in  1  requester consumes the response.
REQ-011 rsp_ins  out  32  fetched instruction word.
REQ-012 rsp_err  out  1  misaligned or out-of-range fetch.
REQ-013 load_en  in  1  program-load write strobe.
REQ-014 load_addr  in  log2(DEPTH)  program-load word index.
REQ-015 load_data  in  32  program-load word.

Function
REQ-016 FSM states: IDLE, WAIT, RESP. One transaction outstanding at most. No pipelining.
REQ-017 IDLE: req_ready=1, rsp_valid=0. A handshake (req_valid&&req_ready) captures req_addr and moves to WAIT, or to RESP directly when LATENCY=1.
REQ-018 WAIT: req_ready=0. Down-counter loaded with LATENCY-1 at acceptance. Enter RESP on the edge where the count reaches zero, so rsp_valid rises exactly LATENCY edges after the acceptance edge.
REQ-019 RESP: rsp_valid=1. rsp_ins and rsp_err are held stable until rsp_ready=1. The handshake edge returns to IDLE. req_ready reasserts the following cycle; there is no back-to-back acceptance on the response edge.
REQ-020 Address check: error when req_addr[1:0]!=0, req_addr<BASE, or req_addr>=BASE+4*DEPTH. There is no wrap-around.
REQ-021 Valid fetch: index=(req_addr-BASE)>>2 and rsp_ins=mem[index], rsp_err=0. Error fetch: rsp_ins=32'h0, rsp_err=1.
REQ-022 rsp_ins is sampled from the array on the edge entering RESP. A load to the same index on that edge is not visible (read-before-write).
REQ-023 load_en writes mem[load_addr]<=load_data on any edge in any state. A load is ignored while reset is asserted.
REQ-024 req_valid while not IDLE has no effect. req_addr is don't-care outside the handshake.
REQ-025 When rsp_ready is held high in RESP, rsp_valid pulses for exactly one cycle.

Reset
REQ-026 Asserting reset forces, asynchronously: state=IDLE, counter=0, rsp_valid=0, rsp_ins=32'h0, rsp_err=0, captured address=0.
REQ-027 req_ready is 0 while reset is asserted. It becomes 1 on the first cycle after deassertion.
REQ-028 Reset during WAIT or RESP silently drops the transaction. No response is produced after release.
REQ-029 Array contents are not reset. A program load must occur after reset.

Structure
REQ-030 Shared package cpu_pkg holds the following:
- the PC reset/base constant 32'h00003000, reused by BASE's default;
- the FSM state enum;
- the instruction width constant (32).
REQ-031 Storage is one sub-module, imem_array: one synchronous write port and one read port. imem_responder holds the FSM, counter, address check and output registers.

Verification
REQ-032 Load 0x3C011234 at index 0. Request 0x00003000 with LATENCY=2 and rsp_ready=1. Required: rsp_valid rises 2 edges after acceptance, rsp_ins=0x3C011234, rsp_err=0, req_ready back to 1 one cycle after the response.
REQ-033 Request each of the following; each must give rsp_err=1 and rsp_ins=0:
- 0x00003002 (misaligned);
- 0x00002FFC (below BASE);
- 0x00004000 (DEPTH=1024, above range).
Request 0x00003FFC: it must return mem[1023] with rsp_err=0.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid and req_addr. Required: rsp_valid, rsp_ins and rsp_err stay constant, no second acceptance occurs, and the transaction completes on the first cycle with rsp_ready=1.
REQ-035 Assert reset low asynchronously, mid-WAIT, between clock edges. Required: rsp_valid=0 immediately. After release, no response appears and req_ready=1 on the first cycle.
REQ-036 Run LATENCY=1, then LATENCY=4, each with back-to-back requests 0x3000 and 0x3004. Then load index 1 with 0xFFFFFFFF on the edge that enters RESP for address 0x3004. Required: the old word is returned; a subsequent fetch of 0x3004 returns 0xFFFFFFFF.
